// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   The rx line passes through a two-flop synchroniser. Each bit is sampled at
//   mid-bit using the same CLK_PER_BIT timing as the matching transmitter.
//   A received byte is held in a one-entry register and handed over with a
//   valid/ack handshake. Framing errors and overruns are reported as pulses.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   rx         in   serial input, asynchronous to clk, idle high
//   data_ack   in   consumer accepts data_out (ignored while data_valid=0)
//   data_out   out  last good byte, LSB received first
//   data_valid out  high from byte completion until the cycle after data_ack
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: new byte completed while previous not acked
//   busy       out  high whenever the receiver is not idle
//
// state | meaning
// IDLE  | waiting for a falling edge on rx_s
// START | timing to the middle of the start bit, rejects glitches
// DATA  | sampling the 8 data bits at mid-bit
// STOP  | sampling the stop bit, delivers the byte or flags a framing error
// BREAK | line held low after a bad stop bit; wait for rx_s high
module uart_rx #(
    parameter int unsigned CLK_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_s;
    logic [15:0] clk_count, clk_count_nxt;
    logic [2:0]  bit_index, bit_index_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        byte_done;
    logic        stop_bad;

    // Synchroniser flops reset to the idle level so reset never fakes a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clk_count <= 16'd0;
            bit_index <= 3'd0;
            shift     <= 8'd0;
        end else begin
            state     <= state_nxt;
            clk_count <= clk_count_nxt;
            bit_index <= bit_index_nxt;
            shift     <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clk_count_nxt = clk_count;
        bit_index_nxt = bit_index;
        shift_nxt     = shift;
        byte_done     = 1'b0;
        stop_bad      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt     = START;
                    clk_count_nxt = 16'd0;
                end
            end
            START: begin
                if (clk_count == HALF_M1) begin
                    clk_count_nxt = 16'd0;
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt     = DATA;
                        bit_index_nxt = 3'd0;
                    end
                end else begin
                    clk_count_nxt = clk_count + 16'd1;
                end
            end
            DATA: begin
                if (clk_count == BIT_M1) begin
                    clk_count_nxt        = 16'd0;
                    shift_nxt[bit_index] = rx_s;
                    if (bit_index == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_index_nxt = bit_index + 3'd1;
                    end
                end else begin
                    clk_count_nxt = clk_count + 16'd1;
                end
            end
            STOP: begin
                if (clk_count == BIT_M1) begin
                    clk_count_nxt = 16'd0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    clk_count_nxt = clk_count + 16'd1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Holding register. A completion in the same cycle as an ack wins: the
    // new byte loads, data_valid stays high and no overrun is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && data_valid && !data_ack;
            if (byte_done) begin
                data_out   <= shift;
                data_valid <= 1'b1;
            end else if (data_valid && data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
